uart_tx_buffer: RTL and testbench

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_buffer_if.sv | 31 +++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_tx_buffer.sv | 116 +++++++++++
 tb/tb_uart_tx_buffer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit buffer.
// Stats counters are built only when UART_TXBUF_STATS_EN is defined.
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STROBE,
    WAIT
  } txbuf_state_t;

  localparam int unsigned CNT_W = 16;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Producer/UART-facing signal bundle of uart_tx_buffer.
// master = producer and UART side, slave = the buffer itself.
interface uart_tx_buffer_if #(
  parameter int unsigned DEPTH = 16
) ();
  import uart_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  byte_t            in_data;
  logic             in_valid;
  logic             in_ready;
  logic             afull;
  byte_t            txdata;
  logic             txclk;
  logic             txready;
  logic [CW-1:0]    count;
  logic [CNT_W-1:0] sent_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output in_data, in_valid, txready,
    input  in_ready, afull, txdata, txclk, count, sent_cnt, drop_cnt
  );

  modport slave (
    input  in_data, in_valid, txready,
    output in_ready, afull, txdata, txclk, count, sent_cnt, drop_cnt
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; full/empty derive from the count.
// Push while full is accepted only together with a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter through a LOAD/STROBE/WAIT handshake.
// Define UART_TXBUF_STATS_EN to build the sent/drop statistics counters.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_LVL = DEPTH - 2
) (
  input logic             clk,
  input logic             reset,
  uart_tx_buffer_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] AfullLvl = CW'(AFULL_LVL);

  txbuf_state_t  state_q, state_d;
  byte_t         txdata_q, txdata_d;
  byte_t         pop_byte_q, pop_byte_d;
  byte_t         fifo_rdata;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW-1:0] fifo_count;

  assign fifo_pop  = (state_q == IDLE) && bus.txready && !fifo_empty;
  // A write while full still lands when the same cycle frees a slot.
  assign fifo_push = bus.in_valid && (!fifo_full || fifo_pop);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (bus.in_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    txdata_d   = txdata_q;
    pop_byte_d = pop_byte_q;
    unique case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          // Popped byte is parked here: a push-through at full reuses its slot.
          pop_byte_d = fifo_rdata;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        txdata_d = pop_byte_q;
        state_d  = STROBE;
      end
      STROBE: state_d = WAIT;
      WAIT: begin
        if (!bus.txready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      txdata_q   <= '0;
      pop_byte_q <= '0;
    end else begin
      state_q    <= state_d;
      txdata_q   <= txdata_d;
      pop_byte_q <= pop_byte_d;
    end
  end

  assign bus.txdata   = txdata_q;
  assign bus.txclk    = (state_q == STROBE);
  assign bus.in_ready = !fifo_full;
  assign bus.afull    = (fifo_count >= AfullLvl);
  assign bus.count    = fifo_count;

`ifdef UART_TXBUF_STATS_EN
  logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             drop;

  assign drop = bus.in_valid && fifo_full && !fifo_pop;

  always_comb begin
    sent_cnt_d = sent_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (state_q == STROBE) sent_cnt_d = sat_inc(sent_cnt_q);
    if (drop)              drop_cnt_d = sat_inc(drop_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sent_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      sent_cnt_q <= sent_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.sent_cnt = sent_cnt_q;
  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.sent_cnt = '0;
  assign bus.drop_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_uart_tx_buffer;
  import uart_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFULL = DEPTH - 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_buffer_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: queue of stored bytes plus the transfer phase
  // (0 idle, 1 load, 2 strobe, 3 wait) and the byte in flight.
  byte_t mq[$];
  int    phase;
  byte_t mhold, mtxd;
  int    msent, mdrop;
  bit    last_push;
  byte_t got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit pop, full;
    if (reset) begin
      mq.delete();
      phase = 0; mtxd = 0; mhold = 0; msent = 0; mdrop = 0; last_push = 0;
    end else begin
      pop  = (phase == 0) && bus.txready && (mq.size() > 0);
      full = (mq.size() == DEPTH);
      last_push = bus.in_valid && (!full || pop);
      if (pop) mhold = mq.pop_front();
      if (last_push) mq.push_back(bus.in_data);
      if (bus.in_valid && !last_push && mdrop < 65535) mdrop++;
      case (phase)
        0: if (pop) phase = 1;
        1: begin mtxd = mhold; phase = 2; end
        2: begin phase = 3; if (msent < 65535) msent++; end
        default: if (!bus.txready) phase = 0;
      endcase
    end
  endtask

  // One clock: advance model with the driven inputs, then compare after the edge.
  task automatic step();
    int es, ed;
    model_update();
    @(posedge clk);
    #1;
`ifdef UART_TXBUF_STATS_EN
    es = msent; ed = mdrop;
`else
    es = 0; ed = 0;
`endif
    check("m_count", 32'(bus.count), 32'(mq.size()));
    check("m_in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
    check("m_afull", 32'(bus.afull), 32'(mq.size() >= AFULL));
    check("m_txclk", 32'(bus.txclk), 32'(phase == 2));
    check("m_txdata", 32'(bus.txdata), 32'(mtxd));
    check("m_sent_cnt", 32'(bus.sent_cnt), 32'(es));
    check("m_drop_cnt", 32'(bus.drop_cnt), 32'(ed));
    if (bus.txclk === 1'b1) got.push_back(bus.txdata);
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.in_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // UART emulation: after each strobe it drops txready for two cycles.
  task automatic drain(input int n, input int bound);
    int low = 0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < bound && got.size() < n; k++) begin
      bus.txready = (low > 0) ? 1'b0 : 1'b1;
      step();
      if (low > 0) low--;
      if (bus.txclk === 1'b1) low = 2;
    end
    check("drain_bytes", 32'(got.size()), 32'(n));
  endtask

  typedef struct {
    bit    rst; bit iv; byte_t d; bit txr;
    int    cnt; bit tclk; byte_t txd; bit rdy;
  } vec_t;
  vec_t tv[14];

  initial begin
    int    low, nxt;
    bit    seen;
    byte_t b;
    reset = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.txready = 1'b0;

    // 'A','B','C' with txready dropped for one cycle while in WAIT.
    tv[0]  = '{1, 0, 8'h00, 1, 0, 0, 8'h00, 1};
    tv[1]  = '{0, 1, 8'h41, 1, 1, 0, 8'h00, 1};
    tv[2]  = '{0, 1, 8'h42, 1, 1, 0, 8'h00, 1};
    tv[3]  = '{0, 1, 8'h43, 1, 2, 1, 8'h41, 1};
    tv[4]  = '{0, 0, 8'h00, 1, 2, 0, 8'h41, 1};
    tv[5]  = '{0, 0, 8'h00, 0, 2, 0, 8'h41, 1};
    tv[6]  = '{0, 0, 8'h00, 1, 1, 0, 8'h41, 1};
    tv[7]  = '{0, 0, 8'h00, 1, 1, 1, 8'h42, 1};
    tv[8]  = '{0, 0, 8'h00, 1, 1, 0, 8'h42, 1};
    tv[9]  = '{0, 0, 8'h00, 0, 1, 0, 8'h42, 1};
    tv[10] = '{0, 0, 8'h00, 1, 0, 0, 8'h42, 1};
    tv[11] = '{0, 0, 8'h00, 1, 0, 1, 8'h43, 1};
    tv[12] = '{0, 0, 8'h00, 1, 0, 0, 8'h43, 1};
    tv[13] = '{0, 0, 8'h00, 0, 0, 0, 8'h43, 1};
    for (int i = 0; i < 14; i++) begin
      reset = tv[i].rst; bus.in_valid = tv[i].iv; bus.in_data = tv[i].d;
      bus.txready = tv[i].txr;
      step();
      check("tv_count", 32'(bus.count), 32'(tv[i].cnt));
      check("tv_txclk", 32'(bus.txclk), 32'(tv[i].tclk));
      check("tv_txdata", 32'(bus.txdata), 32'(tv[i].txd));
      check("tv_in_ready", 32'(bus.in_ready), 32'(tv[i].rdy));
    end
    check("rst_afull", 32'(bus.afull), 32'(0));

    // Fill past full with the UART stalled, then drain.
    bus.txready = 1'b0;
    do_reset();
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("rst_txdata", 32'(bus.txdata), 32'(0));
    for (int i = 0; i < 18; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(i);
      step();
      if (i == 12) check("afull_at_13", 32'(bus.afull), 32'(0));
      if (i == 13) check("afull_at_14", 32'(bus.afull), 32'(1));
      if (i == 14) check("in_ready_at_15", 32'(bus.in_ready), 32'(1));
      if (i == 15) check("in_ready_at_16", 32'(bus.in_ready), 32'(0));
    end
`ifdef UART_TXBUF_STATS_EN
    check("drop_cnt_fill", 32'(bus.drop_cnt), 32'(2));
`else
    check("drop_cnt_fill", 32'(bus.drop_cnt), 32'(0));
`endif
    check("count_full", 32'(bus.count), 32'(16));
    got.delete();
    drain(16, 200);
    for (int k = 0; k < 16 && k < got.size(); k++) check("fill_order", 32'(got[k]), 32'(k));

    // Push-through while full.
    bus.txready = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(8'h80 + i);
      step();
    end
    got.delete();
    bus.in_valid = 1'b1; bus.in_data = 8'h5A; bus.txready = 1'b1;
    step();
    check("count_pushpop_full", 32'(bus.count), 32'(16));
    drain(17, 300);
    if (got.size() == 17) begin
      for (int k = 0; k < 16; k++) check("pp_order", 32'(got[k]), 32'(8'h80 + k));
      check("pp_last_5a", 32'(got[16]), 32'(8'h5A));
    end

    // Stream 40 bytes: pointers wrap.
    bus.txready = 1'b1;
    do_reset();
    got.delete();
    low = 0; nxt = 0;
    for (int k = 0; k < 1000 && got.size() < 40; k++) begin
      bus.in_valid = (nxt < 40); bus.in_data = 8'(8'hC0 + nxt);
      bus.txready = (low > 0) ? 1'b0 : 1'b1;
      step();
      if (last_push) nxt++;
      if (low > 0) low--;
      if (bus.txclk === 1'b1) low = 2;
    end
    check("stream_bytes", 32'(got.size()), 32'(40));
    for (int k = 0; k < 40 && k < got.size(); k++) check("stream_order", 32'(got[k]), 32'(8'(8'hC0 + k)));
    check("stream_count_0", 32'(bus.count), 32'(0));

    // Reset during STROBE with 3 bytes still queued.
    bus.txready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(8'h10 + i);
      step();
    end
    bus.in_valid = 1'b0; bus.txready = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (bus.txclk === 1'b1) seen = 1;
    end
    check("abort_saw_strobe", 32'(seen), 32'(1));
    check("abort_queued", 32'(bus.count), 32'(3));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_txclk", 32'(bus.txclk), 32'(0));
    check("abort_count", 32'(bus.count), 32'(0));
    check("abort_txdata", 32'(bus.txdata), 32'(0));
    for (int k = 0; k < 8; k++) begin
      step();
      check("abort_no_pulse", 32'(bus.txclk), 32'(0));
    end
    got.delete();
    bus.in_valid = 1'b1; bus.in_data = 8'h99;
    step();
    drain(1, 50);
    if (got.size() > 0) check("abort_first_out", 32'(got[0]), 32'(8'h99));

    // Randomized traffic, including occasional resets.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      reset = ($urandom_range(0, 299) == 0);
      bus.in_valid = ($urandom_range(0, 99) < 55);
      b = 8'($urandom);
      bus.in_data = b;
      bus.txready = ($urandom_range(0, 99) < 70);
      step();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
